// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation dispatcher: opcodes, FSM states, default widths.
package fpu_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SQRT = OP_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_op_dispatch_if.sv
// Request/response channels of the FPU dispatcher (valid/ready on both sides).
interface fpu_op_dispatch_if #(
  parameter int unsigned OP_W = fpu_pkg::OP_W,
  parameter int unsigned DW   = fpu_pkg::DW
);

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_result;
  logic [OP_W-1:0] out_op;
  logic            out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_op, out_err
  );

endinterface

// File: rtl/fpu_op_watchdog.sv
// WAIT-state cycle counter; only instanced when FPU_WATCHDOG_EN is defined.
// expired_c fires in the TIMEOUT-th enabled cycle after a clear.
module fpu_op_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then increment while enabled, saturating at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_op_dispatch.sv
// FPU operation dispatcher: accepts one request, issues it to one unit via
// one-hot enable/start, waits for that unit's done and returns the result.
// Optional watchdog on the WAIT state: define FPU_WATCHDOG_EN.
module fpu_op_dispatch #(
  parameter int unsigned N_OPS   = 5,
  parameter int unsigned OP_W    = fpu_pkg::OP_W,
  parameter int unsigned DW      = fpu_pkg::DW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  fpu_op_dispatch_if.slave    bus,
  output logic [N_OPS-1:0]    unit_en,
  output logic [N_OPS-1:0]    unit_start,
  output logic [DW-1:0]       unit_a,
  output logic [DW-1:0]       unit_b,
  input  logic [N_OPS-1:0]    unit_done,
  input  logic [N_OPS*DW-1:0] unit_result
);

  import fpu_pkg::*;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [N_OPS-1:0] en_q, en_d;
  logic [N_OPS-1:0] start_q, start_d;

  logic             op_legal_c;
  logic [N_OPS-1:0] in_onehot_c;
  logic             done_sel_c;
  logic [DW-1:0]    result_sel_c;
  logic             wd_clr_c;
  logic             wd_en_c;
  logic             wd_expired_c;

  function automatic logic [N_OPS-1:0] op_decode(input logic [OP_W-1:0] op);
    logic [N_OPS-1:0] oh;
    oh = '0;
    for (int unsigned k = 0; k < N_OPS; k++) begin
      oh[k] = (32'(op) == k);
    end
    return oh;
  endfunction

  assign op_legal_c  = (32'(bus.in_op) < N_OPS);
  assign in_onehot_c = op_decode(bus.in_op);

  // While waiting, en_q is the one-hot of the selected unit: use it to pick done and result.
  always_comb begin
    result_sel_c = '0;
    for (int unsigned k = 0; k < N_OPS; k++) begin
      if (en_q[k]) begin
        result_sel_c = result_sel_c | unit_result[k*DW +: DW];
      end
    end
  end

  assign done_sel_c = |(unit_done & en_q);

`ifdef FPU_WATCHDOG_EN
  fpu_op_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );
`else
  logic unused_wd_c;
  assign unused_wd_c  = ^{wd_clr_c, wd_en_c, 32'(TIMEOUT)};
  assign wd_expired_c = 1'b0;
`endif

  // Next-state and next-output logic; every output flop gets its next value here.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    err_d       = err_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    en_d        = '0;
    start_d     = '0;
    wd_clr_c    = 1'b0;
    wd_en_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.in_op;
          a_d  = bus.in_a;
          b_d  = bus.in_b;
          if (op_legal_c) begin
            state_d = ST_ISSUE;
            en_d    = in_onehot_c;
            start_d = in_onehot_c;
          end else begin
            state_d     = ST_RESP;
            err_d       = 1'b1;
            result_d    = '0;
            out_valid_d = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT;
        en_d     = en_q;
        wd_clr_c = 1'b1;
      end
      ST_WAIT: begin
        wd_en_c = 1'b1;
        if (done_sel_c) begin
          state_d     = ST_RESP;
          result_d    = result_sel_c;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else if (wd_expired_c) begin
          state_d     = ST_RESP;
          result_d    = '0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          en_d = en_q;
        end
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      en_q        <= '0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      start_q     <= start_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_op     = op_q;
  assign bus.out_err    = err_q;
  assign unit_en        = en_q;
  assign unit_start     = start_q;
  assign unit_a         = a_q;
  assign unit_b         = b_q;

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Bench for fpu_op_dispatch: unit responder model, request scoreboard, protocol monitor.
module tb_fpu_op_dispatch;

  localparam int unsigned N_OPS   = 5;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N_OPS-1:0]    unit_en, unit_start, unit_done;
  logic [DW-1:0]       unit_a, unit_b;
  logic [N_OPS*DW-1:0] unit_result;

  fpu_op_dispatch_if #(.OP_W(OP_W), .DW(DW)) bus ();

  fpu_op_dispatch #(
    .N_OPS(N_OPS), .OP_W(OP_W), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .unit_en(unit_en), .unit_start(unit_start),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result)
  );

  typedef struct {
    logic [OP_W-1:0] op;
    logic [DW-1:0]   res;
    logic            err;
    int              kind;     // 0 unit completion, 1 illegal opcode, 2 watchdog timeout
    int              ref_cyc;  // accept cycle
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // request context handed to the unit responder
  int              cur_op = 0;
  logic [DW-1:0]   cur_a = '0, cur_b = '0;
  int              cur_delay = 1;
  logic            force_en = 1'b0;
  logic [DW-1:0]   force_val = '0;
  logic            never_mode = 1'b0;
  logic            orphan_req = 1'b0;
  logic [N_OPS-1:0] stray_dir = '0;
  int              bp_req_cnt = 0;

  // responder state
  logic            busy = 1'b0;
  int              cnt = 0;
  int              r_op = 0;
  logic [DW-1:0]   r_a = '0, r_b = '0;
  int              done_cyc = 0;
  int              start_cyc = 0;

  // monitor state
  int              bp_done = 0;
  int              hold_left = 0;
  logic            prev_valid = 1'b0;
  logic            ready_chk = 1'b0;
  exp_t            e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N_OPS-1:0] oh(input int op);
    logic [N_OPS-1:0] v;
    v = '0;
    if (op >= 0 && op < int'(N_OPS)) v[op] = 1'b1;
    return v;
  endfunction

  // Reference behaviour of arithmetic unit k (arbitrary but distinct per unit).
  function automatic logic [DW-1:0] unit_fn(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + (b ^ (32'(k) * 32'h0101_0101)) + 32'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unit responder: checks issue, drives done/result after the requested delay, plus stray dones.
  always @(negedge clk) begin
    unit_done = '0;
    for (int k = 0; k < int'(N_OPS); k++) unit_result[k*DW +: DW] = $urandom();
    if (busy && never_mode && bus.out_valid) busy = 1'b0;
    if (unit_start != '0) begin
      if (busy) check("start_repeat", 64'(unit_start), 64'(0));
      check("unit_start", 64'(unit_start), 64'(oh(cur_op)));
      check("unit_en_at_start", 64'(unit_en), 64'(oh(cur_op)));
      check("unit_a", 64'(unit_a), 64'(cur_a));
      check("unit_b", 64'(unit_b), 64'(cur_b));
      busy = 1'b1; cnt = cur_delay; r_op = cur_op; r_a = unit_a; r_b = unit_b; start_cyc = cyc;
    end else if (busy) begin
      if (!never_mode && !orphan_req) check("unit_en_wait", 64'(unit_en), 64'(oh(r_op)));
      if (!never_mode) begin
        cnt--;
        if (cnt == 0) begin
          unit_done[r_op] = 1'b1;
          unit_result[r_op*DW +: DW] = force_en ? force_val : unit_fn(r_op, r_a, r_b);
          done_cyc = cyc;
          busy = 1'b0;
        end else begin
          if ($urandom_range(3) == 0) unit_done = N_OPS'($urandom()) & ~oh(r_op);
          if (cnt == 3) unit_done = unit_done | (stray_dir & ~oh(r_op));
        end
      end
    end else if (!rst && !orphan_req) begin
      check("unit_en_idle", 64'(unit_en), 64'(0));
    end
  end

  // Response monitor: compares every presented response against the scoreboard front.
  always @(negedge clk) begin
    if (ready_chk) begin
      check("in_ready_after_hs", 64'(bus.in_ready), 64'(1));
      ready_chk = 1'b0;
    end
    if (rst) begin
      prev_valid = 1'b0; hold_left = 0; bus.out_ready = 1'b0;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_response: got op %0d result %0h, expected none", bus.out_op, bus.out_result);
      end else begin
        e = q[0];
        if (!prev_valid) begin
          if (e.kind == 0) check("latency_done", 64'(cyc), 64'(done_cyc + 1));
          else if (e.kind == 1) check("latency_illegal", 64'(cyc), 64'(e.ref_cyc + 1));
          else check("latency_timeout", 64'(cyc), 64'(start_cyc + int'(TIMEOUT) + 1));
        end
        check("out_result", 64'(bus.out_result), 64'(e.res));
        check("out_op", 64'(bus.out_op), 64'(e.op));
        check("out_err", 64'(bus.out_err), 64'(e.err));
      end
      if (!prev_valid && bp_done != bp_req_cnt) begin
        hold_left = 10; bp_done++;
      end
      if (hold_left > 0) begin
        bus.out_ready = 1'b0; hold_left--;
      end else begin
        bus.out_ready = ($urandom_range(2) != 0);
      end
      if (bus.out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        ready_chk = 1'b1; prev_valid = 1'b0;
      end else begin
        prev_valid = 1'b1;
      end
    end else begin
      prev_valid = 1'b0;
      bus.out_ready = $urandom_range(1) == 1;
    end
  end

  // Cycle-wise exclusivity and handshake invariants.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (!$onehot0(unit_en) || !$onehot0(unit_start) || ((unit_start & ~unit_en) != '0) ||
          (bus.in_ready && bus.out_valid) || (bus.out_valid && unit_en != '0)) begin
        n_err++;
        $display("FAIL protocol: en %b start %b in_ready %b out_valid %b", unit_en, unit_start, bus.in_ready, bus.out_valid);
      end
    end
  end

  task automatic junk_inputs();
    bus.in_op = OP_W'($urandom()); bus.in_a = $urandom(); bus.in_b = $urandom();
  endtask

  task automatic send(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int delay,
                      input logic fen, input logic [DW-1:0] fval, input logic never);
    exp_t x;
    int guard;
    guard = 0;
    while (!bus.in_ready) begin
      bus.in_valid = !bus.out_valid && ($urandom_range(1) == 1);
      junk_inputs();
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        n_vec++; n_err++;
        $display("FAIL wait_in_ready: got in_ready 0 for %0d cycles, expected 1", guard);
        bus.in_valid = 1'b0;
        return;
      end
    end
    cur_op = op; cur_a = a; cur_b = b; cur_delay = delay;
    force_en = fen; force_val = fval; never_mode = never;
    x.op = OP_W'(op);
    x.err = (op >= int'(N_OPS)) || never;
    x.res = x.err ? '0 : (fen ? fval : unit_fn(op, a, b));
    x.kind = (op >= int'(N_OPS)) ? 1 : (never ? 2 : 0);
    x.ref_cyc = cyc;
    q.push_back(x);
    bus.in_valid = 1'b1; bus.in_op = OP_W'(op); bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    junk_inputs();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 || !bus.in_ready || busy) begin
      @(negedge clk);
      guard++;
      if (guard > 600) begin
        n_vec++; n_err++;
        $display("FAIL drain: got %0d responses outstanding, expected 0", q.size());
        q.delete();
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; junk_inputs();
    unit_done = '0; unit_result = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_unit_en", 64'(unit_en), 64'(0));
    check("rst_unit_start", 64'(unit_start), 64'(0));
    check("rst_out_result", 64'(bus.out_result), 64'(0));
    check("rst_out_op", 64'(bus.out_op), 64'(0));
    check("rst_out_err", 64'(bus.out_err), 64'(0));
    check("rst_unit_a", 64'(unit_a), 64'(0));
    check("rst_unit_b", 64'(unit_b), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // ADD with a 3-cycle unit
    send(int'(fpu_pkg::OP_ADD), 32'h3F80_0000, 32'h4000_0000, 3, 1'b1, 32'h4040_0000, 1'b0);
    drain();
    // illegal opcode
    send(6, $urandom(), $urandom(), 1, 1'b0, '0, 1'b0);
    drain();
    // backpressure for 10 cycles
    bp_req_cnt++;
    send(int'(fpu_pkg::OP_SUB), $urandom(), $urandom(), 2, 1'b0, '0, 1'b0);
    drain();
    // stray done from unit 2 while DIV is in flight
    stray_dir = 5'b00100;
    send(int'(fpu_pkg::OP_DIV), $urandom(), $urandom(), 6, 1'b1, 32'hC0A0_0000, 1'b0);
    drain();
    stray_dir = '0;

    // reset during WAIT; the late done must be ignored
    send(int'(fpu_pkg::OP_MUL), $urandom(), $urandom(), 8, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    orphan_req = 1'b1; rst = 1'b1; q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_unit_en", 64'(unit_en), 64'(0));
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    end
    check("orphan_done_emitted", 64'(busy), 64'(0));
    orphan_req = 1'b0;

    // randomized traffic, including illegal opcodes and occasional long backpressure
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(14) == 0) bp_req_cnt++;
      send(int'($urandom_range(7)), $urandom(), $urandom(), int'($urandom_range(5, 1)), 1'b0, '0, 1'b0);
    end
    drain();

`ifdef FPU_WATCHDOG_EN
    // unit never completes: watchdog response
    send(int'(fpu_pkg::OP_SQRT), $urandom(), $urandom(), 1, 1'b0, '0, 1'b1);
    drain();
    never_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no completion by %0t, expected finish", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fpu_op_dispatch.md
Name: fpu_op_dispatch

Overview:
Parametrised FPU operation dispatcher. It accepts one operation request at a time over a valid/ready handshake and issues it to one of N_OPS arithmetic units through a per-unit clock enable and start pulse. It then waits for that unit's done, captures the result and returns it over a valid/ready response channel. Units run on the common clk and are selected by clock enable only; no clock gating.

Parameters:
N_OPS, 5, number of arithmetic units / legal opcodes (0..N_OPS-1)
OP_W, 3, opcode width; must satisfy 2**OP_W >= N_OPS
DW, 32, operand/result width (IEEE-754 single)
TIMEOUT, 64, watchdog limit in cycles; used only when FPU_WATCHDOG_EN is defined

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  request accept; high only in IDLE
in_op  in  OP_W  opcode
in_a  in  DW  operand A
in_b  in  DW  operand B
unit_en  out  N_OPS  one-hot clock enable to units
unit_start  out  N_OPS  one-hot single-cycle start pulse
unit_a  out  DW  registered operand A, broadcast to all units
unit_b  out  DW  registered operand B, broadcast to all units
unit_done  in  N_OPS  per-unit completion pulse/level
unit_result  in  N_OPS*DW  packed unit results; unit k occupies bits [k*DW +: DW]
out_valid  out  1  response valid
out_ready  in  1  response accept
out_result  out  DW  captured result
out_op  out  OP_W  opcode of this response
out_err  out  1  illegal opcode, or watchdog timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, except in_ready=1 in the first cycle after reset. State is IDLE; operand, op and result registers are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_op, in_a and in_b.
  - If in_op < N_OPS, go to ISSUE; otherwise go to RESP with out_err=1 and out_result=0.
- ISSUE (exactly 1 cycle):
  - unit_start[op]=1 and unit_en[op]=1; then go to WAIT.
  - unit_done is ignored in this cycle. Units must not assert done in their start cycle.
- WAIT:
  - unit_en[op]=1 and all other unit_en bits 0.
  - When unit_done[op]=1, capture unit_result[op] into out_result and set out_err=0, out_op=op; go to RESP.
  - unit_en[op] is still high in the done cycle and drops in the next cycle.
  - done bits of non-selected units are ignored.
- RESP:
  - out_valid=1, with out_result, out_op and out_err held stable until out_ready.
  - On out_valid & out_ready, go to IDLE. in_ready rises in the following cycle; no same-cycle turnaround.
- Latency: accept at cycle t gives ISSUE at t+1. Done at cycle d gives out_valid at d+1. An illegal opcode gives out_valid at t+1.
- Exclusivity: unit_en and unit_start are zero or one-hot in every cycle. unit_start is never high outside ISSUE.
- Operand stability: unit_a and unit_b are stable from ISSUE until return to IDLE.
- Reset in any state: return to IDLE next cycle and drop unit_en and out_valid immediately. The in-flight result is discarded.
- Requests are never queued. in_valid outside IDLE is ignored by handshake (in_ready=0).

Optional Feature:
FPU_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without done, go to RESP with out_err=1, out_result=0 and out_op=op, and drop unit_en.
  - A done arriving in the same cycle as the timeout takes priority (normal completion).
- Undefined: WAIT persists until done, no counter logic is built and TIMEOUT is unused.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_SQRT=4;
  - the FSM state encoding;
  - default widths DW=32, OP_W=3.
- Natural sub-module: fpu_op_watchdog, a TIMEOUT counter with clear/enable inputs and an expired output. It is instanced only under FPU_WATCHDOG_EN.

Test Plan:
- ADD, basic completion:
  - Stimulus: op=0, a=0x3F800000, b=0x40000000; unit0 model asserts done 3 cycles after start with 0x40400000.
  - Response: unit_start=5'b00001 for one cycle, unit_en=5'b00001 through the done cycle, then out_valid with result 0x40400000, op=0, err=0.
- Illegal opcode: op=6 -> no unit_en/unit_start activity; out_valid at t+1 with out_err=1 and out_result=0.
- Backpressure: out_ready held low for 10 cycles after out_valid -> out_result/out_op stable throughout, in_ready=0; 1 cycle after the handshake, in_ready=1.
- Stray done: op=3 in flight, unit_done=5'b00100 pulsed -> ignored. Then unit_done[3] with 0xC0A00000 -> out_result=0xC0A00000.
- Reset mid-operation: rst for 1 cycle during WAIT -> next cycle unit_en=0, out_valid=0, in_ready=1. A late unit_done is ignored.
- Watchdog (FPU_WATCHDOG_EN, TIMEOUT=16): the unit never completes -> out_err=1, out_result=0, out_valid 17 cycles after ISSUE, unit_en dropped.
